i281_fetch_decode: RTL

//  Upstream neighbour of the control logic generator: holds the PC, fetches 16-bit instruction words,

---
 rtl/i281_pkg.sv | 56 +++++
 rtl/i281_op_decoder.sv | 41 ++++
 rtl/i281_fetch_decode.sv | 101 ++++++++++
 3 files changed

// File: rtl/i281_pkg.sv
// Shared i281 ISA definitions: opcodes, one-hot op indices, flag positions.
// Used by the decoder, the fetch/decode top and any ISA-level model.
package i281_pkg;

   localparam int OP_W = 27;

   localparam logic [3:0] OPC_NOOP   = 4'h0;
   localparam logic [3:0] OPC_INPUT  = 4'h1;
   localparam logic [3:0] OPC_MOVE   = 4'h2;
   localparam logic [3:0] OPC_LOADI  = 4'h3;
   localparam logic [3:0] OPC_ADD    = 4'h4;
   localparam logic [3:0] OPC_ADDI   = 4'h5;
   localparam logic [3:0] OPC_SUB    = 4'h6;
   localparam logic [3:0] OPC_SUBI   = 4'h7;
   localparam logic [3:0] OPC_LOAD   = 4'h8;
   localparam logic [3:0] OPC_LOADF  = 4'h9;
   localparam logic [3:0] OPC_STORE  = 4'hA;
   localparam logic [3:0] OPC_STOREF = 4'hB;
   localparam logic [3:0] OPC_SHIFT  = 4'hC;
   localparam logic [3:0] OPC_CMP    = 4'hD;
   localparam logic [3:0] OPC_JUMP   = 4'hE;
   localparam logic [3:0] OPC_BRANCH = 4'hF;

   localparam logic [4:0] OP_NOOP    = 5'd0;
   localparam logic [4:0] OP_INPUTC  = 5'd1;
   localparam logic [4:0] OP_INPUTCF = 5'd2;
   localparam logic [4:0] OP_INPUTD  = 5'd3;
   localparam logic [4:0] OP_INPUTDF = 5'd4;
   localparam logic [4:0] OP_MOVE    = 5'd5;
   localparam logic [4:0] OP_LOADI   = 5'd6;
   localparam logic [4:0] OP_ADD     = 5'd7;
   localparam logic [4:0] OP_ADDI    = 5'd8;
   localparam logic [4:0] OP_SUB     = 5'd9;
   localparam logic [4:0] OP_SUBI    = 5'd10;
   localparam logic [4:0] OP_LOAD    = 5'd11;
   localparam logic [4:0] OP_LOADF   = 5'd12;
   localparam logic [4:0] OP_STORE   = 5'd13;
   localparam logic [4:0] OP_STOREF  = 5'd14;
   localparam logic [4:0] OP_SHIFTL  = 5'd15;
   localparam logic [4:0] OP_SHIFTR  = 5'd16;
   localparam logic [4:0] OP_CMP     = 5'd17;
   localparam logic [4:0] OP_JUMP    = 5'd18;
   localparam logic [4:0] OP_BRE     = 5'd19;
   localparam logic [4:0] OP_BRNE    = 5'd20;
   localparam logic [4:0] OP_BRG     = 5'd21;
   localparam logic [4:0] OP_BRGE    = 5'd22;

   // Flag register bit order is {Z,N,O,C}.
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_O = 1;
   localparam int FLAG_C = 0;

   typedef logic [OP_W-1:0] op_vec_t;

endpackage

// File: rtl/i281_op_decoder.sv
// Pure combinational i281 instruction decoder: 16-bit word -> one-hot op
// in [22:0] plus the operand field instr[11:8] in [26:23].
module i281_op_decoder
   import i281_pkg::*;
(
   input  logic [15:0] instr,
   output logic [26:0] op
);

   logic [4:0] idx;

   always_comb begin
      idx = OP_NOOP;
      case (instr[15:12])
         OPC_NOOP:   idx = OP_NOOP;
         OPC_INPUT:  idx = OP_INPUTC + {3'b000, instr[9:8]};
         OPC_MOVE:   idx = OP_MOVE;
         OPC_LOADI:  idx = OP_LOADI;
         OPC_ADD:    idx = OP_ADD;
         OPC_ADDI:   idx = OP_ADDI;
         OPC_SUB:    idx = OP_SUB;
         OPC_SUBI:   idx = OP_SUBI;
         OPC_LOAD:   idx = OP_LOAD;
         OPC_LOADF:  idx = OP_LOADF;
         OPC_STORE:  idx = OP_STORE;
         OPC_STOREF: idx = OP_STOREF;
         OPC_SHIFT:  idx = instr[8] ? OP_SHIFTR : OP_SHIFTL;
         OPC_CMP:    idx = OP_CMP;
         OPC_JUMP:   idx = OP_JUMP;
         OPC_BRANCH: idx = OP_BRE + {3'b000, instr[9:8]};
         default:    idx = OP_NOOP;
      endcase
   end

   always_comb begin
      op        = '0;
      op[idx]   = 1'b1;
      op[26:23] = instr[11:8];
   end

endmodule

// File: rtl/i281_fetch_decode.sv
// i281 fetch/decode stage: PC, one-entry decoded-op register and flag register.
// Optional FLAG_FWD_EN forwards flag_alu to flag_out in the cycle it is written.
module i281_fetch_decode
   import i281_pkg::*;
#(
   parameter int              PC_W     = 6,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_instr,
   input  logic            imem_valid,
   output logic            imem_ready,
   input  logic            pc_load,
   input  logic [PC_W-1:0] pc_target,
   output logic [26:0]     op_out,
   output logic [7:0]      imm_out,
   output logic [PC_W-1:0] op_pc,
   output logic            op_valid,
   input  logic            op_ready,
   input  logic            flag_we,
   input  logic [3:0]      flag_alu,
   output logic [3:0]      flag_out
);

   // Handshake: a transfer happens on an edge where valid and ready are both
   // high; valid never depends on ready, and a held op stays stable until taken.
   logic [PC_W-1:0] pc_q, pc_d;
   op_vec_t         op_q, op_d;
   logic [7:0]      imm_q, imm_d;
   logic [PC_W-1:0] op_pc_q, op_pc_d;
   logic            valid_q, valid_d;
   logic [3:0]      flag_q, flag_d;
   op_vec_t         dec_op;
   logic            accept;

   i281_op_decoder u_dec (
      .instr (imem_instr),
      .op    (dec_op)
   );

   assign imem_ready = !valid_q || op_ready;
   assign accept     = imem_valid && imem_ready && !pc_load;

   always_comb begin
      pc_d    = pc_q;
      op_d    = op_q;
      imm_d   = imm_q;
      op_pc_d = op_pc_q;
      valid_d = valid_q;
      // A redirect wins over everything: the word on the bus belongs to the old path.
      if (pc_load) begin
         pc_d    = pc_target;
         valid_d = 1'b0;
      end else if (accept) begin
         pc_d    = pc_q + PC_W'(1);
         op_d    = dec_op;
         imm_d   = imem_instr[7:0];
         op_pc_d = pc_q;
         valid_d = 1'b1;
      end else if (valid_q && op_ready) begin
         valid_d = 1'b0;
      end
   end

   always_comb begin
      flag_d = flag_we ? flag_alu : flag_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q    <= RESET_PC;
         op_q    <= '0;
         imm_q   <= '0;
         op_pc_q <= '0;
         valid_q <= 1'b0;
         flag_q  <= '0;
      end else begin
         pc_q    <= pc_d;
         op_q    <= op_d;
         imm_q   <= imm_d;
         op_pc_q <= op_pc_d;
         valid_q <= valid_d;
         flag_q  <= flag_d;
      end
   end

   assign imem_addr = pc_q;
   assign op_out    = op_q;
   assign imm_out   = imm_q;
   assign op_pc     = op_pc_q;
   assign op_valid  = valid_q;

`ifdef FLAG_FWD_EN
   assign flag_out = flag_we ? flag_alu : flag_q;
`else
   assign flag_out = flag_q;
`endif

endmodule
